// File: rtl/membus_arbiter.sv
// membus_arbiter
//   Round-robin arbiter sharing the single-master internal memory bus between
//   port A (host interface) and port B (sample logger). One transaction is in
//   flight at a time; every output is a register.
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   {a,b}_req/we/addr/wdata_i    requester inputs, held stable until gnt
//   {a,b}_gnt_o                  one-cycle pulse, request accepted
//   {a,b}_ack_o                  one-cycle pulse, transaction complete
//   {a,b}_rdata_o                read data, updated only on that port's read ack
//   membus_read_req_o/write_req_o  one-cycle strobes to the slaves
//   membus_addr_o/data_o         bus address / write data, held between transactions
//   membus_data_i                resolved slave read data
// READ_LAT (1..7): cycles from strobe to valid membus_data_i.
module membus_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       a_req_i,
  input  logic       a_we_i,
  input  logic [6:0] a_addr_i,
  input  logic [7:0] a_wdata_i,
  input  logic       b_req_i,
  input  logic       b_we_i,
  input  logic [6:0] b_addr_i,
  input  logic [7:0] b_wdata_i,
  output logic       a_gnt_o,
  output logic       a_ack_o,
  output logic [7:0] a_rdata_o,
  output logic       b_gnt_o,
  output logic       b_ack_o,
  output logic [7:0] b_rdata_o,
  output logic       membus_read_req_o,
  output logic       membus_write_req_o,
  output logic [6:0] membus_addr_o,
  output logic [7:0] membus_data_o,
  input  logic [7:0] membus_data_i
);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, ACK} state_t;

  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
  } req_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;   // 0 = A has priority, 1 = B
  logic       win_q, win_d;   // port owning the current transaction
  logic       we_q, we_d;
  logic [2:0] cnt_q, cnt_d;

  logic       a_gnt_d, b_gnt_d, a_ack_d, b_ack_d, rd_d, wr_d;
  logic [6:0] addr_d;
  logic [7:0] data_d, a_rdata_d, b_rdata_d;
  logic       pick;
  req_t       sel;

  // Outputs are registered, so each output is computed for the state being
  // entered: strobe/gnt on entry to STROBE, ack/rdata on entry to ACK.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    a_gnt_d   = 1'b0;
    b_gnt_d   = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    addr_d    = membus_addr_o;
    data_d    = membus_data_o;
    a_rdata_d = a_rdata_o;
    b_rdata_d = b_rdata_o;
    // B wins when it is alone, or when both ask and the pointer favours B.
    pick      = b_req_i && (!a_req_i || ptr_q);
    sel       = pick ? req_t'{b_we_i, b_addr_i, b_wdata_i}
                     : req_t'{a_we_i, a_addr_i, a_wdata_i};
    unique case (state_q)
      IDLE, ACK: begin
        if (a_req_i || b_req_i) begin
          win_d   = pick;
          we_d    = sel.we;
          addr_d  = sel.addr;
          data_d  = sel.wdata;
          wr_d    = sel.we;
          rd_d    = !sel.we;
          a_gnt_d = !pick;
          b_gnt_d = pick;
          state_d = STROBE;
        end else begin
          state_d = IDLE;
        end
      end
      STROBE: begin
        ptr_d = !win_q;
        if (we_q) begin
          a_ack_d = !win_q;
          b_ack_d = win_q;
          state_d = ACK;
        end else begin
          cnt_d   = 3'(READ_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (win_q) b_rdata_d = membus_data_i;
          else       a_rdata_d = membus_data_i;
          a_ack_d = !win_q;
          b_ack_d = win_q;
          state_d = ACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q            <= IDLE;
      ptr_q              <= 1'b0;
      win_q              <= 1'b0;
      we_q               <= 1'b0;
      cnt_q              <= 3'd0;
      a_gnt_o            <= 1'b0;
      b_gnt_o            <= 1'b0;
      a_ack_o            <= 1'b0;
      b_ack_o            <= 1'b0;
      a_rdata_o          <= 8'd0;
      b_rdata_o          <= 8'd0;
      membus_read_req_o  <= 1'b0;
      membus_write_req_o <= 1'b0;
      membus_addr_o      <= 7'd0;
      membus_data_o      <= 8'd0;
    end else begin
      state_q            <= state_d;
      ptr_q              <= ptr_d;
      win_q              <= win_d;
      we_q               <= we_d;
      cnt_q              <= cnt_d;
      a_gnt_o            <= a_gnt_d;
      b_gnt_o            <= b_gnt_d;
      a_ack_o            <= a_ack_d;
      b_ack_o            <= b_ack_d;
      a_rdata_o          <= a_rdata_d;
      b_rdata_o          <= b_rdata_d;
      membus_read_req_o  <= rd_d;
      membus_write_req_o <= wr_d;
      membus_addr_o      <= addr_d;
      membus_data_o      <= data_d;
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter
//   Directed scenarios plus a randomized run against a transaction-level
//   timeline model. dut uses READ_LAT=1, dut3 uses READ_LAT=3; both share a
//   slave memory model that drives read data only in the valid cycle (X otherwise).
module tb_membus_arbiter;
  localparam int N = 400;
  localparam int M = N + 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_ack, b_gnt, b_ack, rd, wr;
  logic [7:0] a_rdata, b_rdata, wdat, rdat_i;
  logic [6:0] addr;

  logic       a_req3;
  logic [6:0] a_addr3, addr3;
  logic       a_gnt3, a_ack3, b_gnt3, b_ack3, rd3, wr3;
  logic [7:0] a_rdata3, b_rdata3, wdat3, rdat3_i;

  membus_arbiter #(.READ_LAT(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .a_gnt_o(a_gnt), .a_ack_o(a_ack), .a_rdata_o(a_rdata),
    .b_gnt_o(b_gnt), .b_ack_o(b_ack), .b_rdata_o(b_rdata),
    .membus_read_req_o(rd), .membus_write_req_o(wr),
    .membus_addr_o(addr), .membus_data_o(wdat), .membus_data_i(rdat_i));

  membus_arbiter #(.READ_LAT(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req3), .a_we_i(1'b0), .a_addr_i(a_addr3), .a_wdata_i(8'd0),
    .b_req_i(1'b0), .b_we_i(1'b0), .b_addr_i(7'd0), .b_wdata_i(8'd0),
    .a_gnt_o(a_gnt3), .a_ack_o(a_ack3), .a_rdata_o(a_rdata3),
    .b_gnt_o(b_gnt3), .b_ack_o(b_ack3), .b_rdata_o(b_rdata3),
    .membus_read_req_o(rd3), .membus_write_req_o(wr3),
    .membus_addr_o(addr3), .membus_data_o(wdat3), .membus_data_i(rdat3_i));

  // Slave memory model
  logic [7:0] mem [128];
  logic       poke_en;
  logic [6:0] poke_addr;
  logic [7:0] poke_data;
  logic [8:0] p1;
  logic [8:0] p3 [3];

  always @(posedge clk) begin
    if (wr) mem[addr] <= wdat;
    if (poke_en) mem[poke_addr] <= poke_data;
    p1    <= {rd, mem[addr]};
    p3[0] <= {rd3, mem[addr3]};
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign rdat_i  = p1[8]    ? p1[7:0]    : 8'hxx;
  assign rdat3_i = p3[2][8] ? p3[2][7:0] : 8'hxx;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [6:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    step();
    poke_en = 1'b0;
  endtask

  // Reference model state
  logic [5:0]  e_ctl  [M];   // {a_gnt,b_gnt,a_ack,b_ack,rd,wr}
  logic [14:0] e_bus  [M];   // {addr,data}
  logic [15:0] e_rdat [M];   // {a_rdata,b_rdata}
  logic [7:0]  ref_mem [16];
  int          free_at, w, g, ak, ng, n_ack, cyc;
  logic        ptr, swe, both;
  logic [6:0]  sad;
  logic [7:0]  swd, v;

  initial begin
    rst = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 7'h10; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 7'h00; b_wdata = 8'h00;
    a_req3 = 1'b0; a_addr3 = 7'h00;

    // 1: reset held two cycles with a request pending
    poke(7'h10, 8'h3C);
    step();
    chk("reset outputs", 64'({a_gnt, a_ack, b_gnt, b_ack, rd, wr, addr, wdat, a_rdata, b_rdata}), 64'd0);
    chk("reset outputs dut3", 64'({a_gnt3, a_ack3, rd3, wr3, addr3, a_rdata3}), 64'd0);
    rst = 1'b0;
    chk("no gnt at reset release", 64'(a_gnt), 64'd0);
    step();
    chk("first gnt after reset", 64'({a_gnt, rd, addr}), 64'({1'b1, 1'b1, 7'h10}));
    a_req = 1'b0;
    step();
    chk("t1 wait no ack", 64'(a_ack), 64'd0);
    step();
    chk("t1 ack data", 64'({a_ack, a_rdata}), 64'({1'b1, 8'h3C}));
    step();

    // 2: A read of 0x10
    poke(7'h10, 8'h5A);
    a_req = 1'b1; a_we = 1'b0; a_addr = 7'h10;
    step();
    chk("t2 strobe", 64'({a_gnt, b_gnt, rd, wr, addr}), 64'({1'b1, 1'b0, 1'b1, 1'b0, 7'h10}));
    a_req = 1'b0;
    step();
    chk("t2 wait", 64'({a_ack, rd, a_gnt}), 64'd0);
    step();
    chk("t2 ack", 64'({a_ack, a_rdata, b_rdata}), 64'({1'b1, 8'h5A, 8'h00}));
    step();

    // 3: B write 0x20 <= 0xC3
    b_req = 1'b1; b_we = 1'b1; b_addr = 7'h20; b_wdata = 8'hC3;
    step();
    chk("t3 strobe", 64'({wr, rd, b_gnt, a_gnt, addr, wdat}), 64'({1'b1, 1'b0, 1'b1, 1'b0, 7'h20, 8'hC3}));
    b_req = 1'b0;
    step();
    chk("t3 ack", 64'({wr, rd, b_ack, a_rdata}), 64'({1'b0, 1'b0, 1'b1, 8'h5A}));
    step();
    chk("t3 bus hold", 64'({b_ack, rd, wr, addr, wdat}), 64'({3'b000, 7'h20, 8'hC3}));

    // 4: continuous contention
    poke(7'h10, 8'h34);
    poke(7'h11, 8'h12);
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 7'h10;
    b_req = 1'b1; b_we = 1'b0; b_addr = 7'h11;
    step();
    rst = 1'b0;
    ng = 0; n_ack = 0; cyc = 0; both = 1'b0;
    while ((ng < 8 || n_ack < 8) && cyc < 200) begin
      step();
      cyc++;
      if (rd && wr) both = 1'b1;
      if (a_gnt || b_gnt) begin
        chk("t4 grant order", 64'({a_gnt, b_gnt}), (ng % 2 == 0) ? 64'd2 : 64'd1);
        ng++;
        if (ng == 8) begin a_req = 1'b0; b_req = 1'b0; end
      end
      if (a_ack) begin chk("t4 a data", 64'(a_rdata), 64'h34); n_ack++; end
      if (b_ack) begin chk("t4 b data", 64'(b_rdata), 64'h12); n_ack++; end
    end
    chk("t4 completed", {32'(ng), 32'(n_ack)}, {32'd8, 32'd8});
    chk("t4 strobes exclusive", 64'(both), 64'd0);
    step();

    // 5: reset during the WAIT of an A read
    a_req = 1'b1; a_addr = 7'h10;
    step();
    chk("t5 gnt", 64'(a_gnt), 64'd1);
    a_req = 1'b0;
    step();
    chk("t5 wait", 64'(a_ack), 64'd0);
    rst = 1'b1;
    step();
    chk("t5 abandoned", 64'({a_ack, a_rdata, rd, wr, a_gnt}), 64'd0);
    rst = 1'b0;
    step();
    chk("t5 no late ack", 64'({a_ack, rd, wr}), 64'd0);
    step();
    chk("t5 no late ack 2", 64'({a_ack, a_gnt}), 64'd0);
    a_req = 1'b1;
    step();
    chk("t5 fresh gnt", 64'({a_gnt, rd}), 64'd3);
    a_req = 1'b0;
    step();
    step();
    chk("t5 fresh ack", 64'({a_ack, a_rdata}), 64'({1'b1, 8'h34}));

    // 6: READ_LAT=3
    poke(7'h10, 8'h77);
    a_req3 = 1'b1; a_addr3 = 7'h10;
    step();
    chk("t6 strobe", 64'({a_gnt3, rd3, addr3}), 64'({1'b1, 1'b1, 7'h10}));
    a_req3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6 no early ack", 64'({a_ack3, a_rdata3}), 64'd0);
    end
    step();
    chk("t6 ack data", 64'({a_ack3, a_rdata3}), 64'({1'b1, 8'h77}));

    // Randomized run against the timeline model
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      poke(7'(i), v);
      ref_mem[i] = v;
    end
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < M; k++) begin
      e_ctl[k] = '0; e_bus[k] = '0; e_rdat[k] = '0;
    end
    ptr = 1'b0; free_at = 0;
    for (int c = 0; c < N; c++) begin
      chk("rnd control", 64'({a_gnt, b_gnt, a_ack, b_ack, rd, wr}), 64'(e_ctl[c]));
      chk("rnd bus", 64'({addr, wdat}), 64'(e_bus[c]));
      chk("rnd rdata", 64'({a_rdata, b_rdata}), 64'(e_rdat[c]));
      if (a_gnt || !a_req) begin
        a_req = ($urandom_range(99) < 45); a_we = 1'($urandom_range(1));
        a_addr = 7'($urandom_range(15)); a_wdata = 8'($urandom);
      end else if ($urandom_range(99) < 5) a_req = 1'b0;
      if (b_gnt || !b_req) begin
        b_req = ($urandom_range(99) < 45); b_we = 1'($urandom_range(1));
        b_addr = 7'($urandom_range(15)); b_wdata = 8'($urandom);
      end else if ($urandom_range(99) < 5) b_req = 1'b0;
      if (c >= free_at && (a_req || b_req)) begin
        w   = (a_req && b_req) ? int'(ptr) : (b_req ? 1 : 0);
        swe = w ? b_we : a_we;
        sad = w ? b_addr : a_addr;
        swd = w ? b_wdata : a_wdata;
        g   = c + 1;
        e_ctl[g][5 - w] = 1'b1;
        e_ctl[g][swe ? 0 : 1] = 1'b1;
        for (int k = g; k < M; k++) e_bus[k] = {sad, swd};
        if (swe) begin
          ak = c + 2;
          ref_mem[sad[3:0]] = swd;
        end else begin
          ak = c + 3;
          v  = ref_mem[sad[3:0]];
          for (int k = ak; k < M; k++)
            if (w == 1) e_rdat[k][7:0] = v; else e_rdat[k][15:8] = v;
        end
        e_ctl[ak][3 - w] = 1'b1;
        free_at = ak;
        ptr = (w == 0);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
